prog_frame_parser: RTL and testbench

PROG_FRAME_PARSER -- requirements
Module: prog_frame_parser

---
 rtl/prog_pkg.sv | 27 ++
 rtl/prog_word_packer.sv | 44 ++++
 rtl/prog_frame_parser.sv | 178 +++++++++++++++++
 tb/tb_prog_frame_parser.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// ============================================================================
// prog_pkg : shared constants and state encoding for the programming-frame parser
// Revision : 1.0
// ============================================================================
`default_nettype none

package prog_pkg;

  localparam logic [7:0] PROG_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_LEN     = 3'd3,
    ST_DATA    = 3'd4,
    ST_CHK     = 3'd5
  } prog_state_e;

  // A LEN byte of zero encodes the maximum burst of 256 words.
  function automatic logic [8:0] prog_len_to_words(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_word_packer.sv
// ============================================================================
// prog_word_packer : shifts bytes into a little-endian 32-bit word, flags each 4th
// Revision : 1.0
// ============================================================================
`default_nettype none

module prog_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic        done_q;

  // New bytes enter at the top, so the first byte of a word settles in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clr_i) begin
        cnt_q <= 2'd0;
      end else if (byte_valid_i) begin
        word_q <= {byte_i, word_q[31:8]};
        cnt_q  <= cnt_q + 2'd1;
        done_q <= (cnt_q == 2'd3);
      end
    end
  end

  assign word_o      = word_q;
  assign word_done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/prog_frame_parser.sv
// ============================================================================
// prog_frame_parser : parses SYNC/ADDR/LEN/payload[/CHK] frames into memory writes
// Optional feature macro: PROG_CHECKSUM_EN (adds the trailing checksum byte)
// Revision : 1.0
// ============================================================================
`default_nettype none

module prog_frame_parser
  import prog_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_data,
  output logic [3:0]            m_we,
  output logic                  m_en,
  output logic                  busy,
  output logic                  frame_ok,
  output logic                  frame_err
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  prog_state_e           state_q, state_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            words_q, words_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
`ifdef PROG_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic                  w_acc;
  logic                  w_strobe;
  logic [31:0]           w_word;
  logic [ADDR_WIDTH+15:0] w_start_full;

  assign w_acc        = s_valid && s_ready;
  assign w_start_full = {{ADDR_WIDTH{1'b0}}, hi_q, s_data};

  prog_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (state_q == ST_IDLE),
    .byte_valid_i (w_acc && (state_q == ST_DATA)),
    .byte_i       (s_data),
    .word_o       (w_word),
    .word_done_o  (w_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= 8'd0;
      addr_q  <= '0;
      words_q <= 9'd0;
      tmo_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
`ifdef PROG_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    words_d = words_q;
    tmo_d   = tmo_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
`ifdef PROG_CHECKSUM_EN
    sum_d   = sum_q;
    if (state_q == ST_IDLE) begin
      sum_d = 8'd0;
    end else if (w_acc && (state_q != ST_CHK)) begin
      sum_d = sum_q + s_data;
    end
`endif

    if (w_acc || (state_q == ST_IDLE)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (w_strobe) begin
      addr_d  = addr_q + 1'b1;
      words_d = words_q - 9'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_acc && (s_data == PROG_SYNC_BYTE)) state_d = ST_ADDR_HI;
      end
      ST_ADDR_HI: begin
        if (w_acc) begin
          hi_d    = s_data;
          state_d = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (w_acc) begin
          addr_d  = w_start_full[ADDR_WIDTH-1:0];
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_acc) begin
          words_d = prog_len_to_words(s_data);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // The frame's last word is decided in its strobe cycle, when no byte can arrive.
        if (w_strobe && (words_q == 9'd1)) begin
`ifdef PROG_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_IDLE;
          ok_d    = 1'b1;
`endif
        end
      end
`ifdef PROG_CHECKSUM_EN
      ST_CHK: begin
        if (w_acc) begin
          state_d = ST_IDLE;
          if ((sum_q + s_data) == 8'd0) ok_d = 1'b1;
          else                          err_d = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && !w_acc && (tmo_q == TMO_LAST)) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      ok_d    = 1'b0;
      err_d   = 1'b1;
    end
  end

  assign s_ready   = !w_strobe;
  assign m_en      = w_strobe;
  assign m_we      = {4{w_strobe}};
  assign m_addr    = addr_q;
  assign m_data    = w_word;
  assign busy      = (state_q != ST_IDLE);
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_frame_parser.sv
// ============================================================================
// tb_prog_frame_parser : table-driven frame vectors plus timeout/reset sequences
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_prog_frame_parser;

`ifdef PROG_CHECKSUM_EN
  localparam int CHK_ON = 1;
`else
  localparam int CHK_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_we;
  logic        m_en;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int ok_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  seed;
    logic [7:0]  chk_delta;
    int          exp_writes;
    logic [11:0] exp_first_addr;
    logic [11:0] exp_last_addr;
    logic [31:0] exp_first_data;
    int          exp_ok;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  prog_frame_parser #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_we      (m_we),
    .m_en      (m_en),
    .busy      (busy),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] pay(input logic [7:0] seed, input int k);
    return 8'(int'(seed) + 17 * (k + 1));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("s_ready_vs_strobe", 32'(s_ready), 32'(!m_en));
      check("we_vs_en", 32'(m_we), 32'({4{m_en}}));
      check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
      if (m_en) begin
        wr_addr.push_back(m_addr);
        wr_data.push_back(m_data);
      end
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 8) check("s_ready_wait", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    ok_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          nw;
    int          bad;
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] w;
    clear_log();
    nw  = (v.len == 8'd0) ? 256 : int'(v.len);
    sum = 8'd0;
    send_byte(8'hA5);
    send_byte(v.addr[15:8]); sum = sum + v.addr[15:8];
    send_byte(v.addr[7:0]);  sum = sum + v.addr[7:0];
    send_byte(v.len);        sum = sum + v.len;
    for (int k = 0; k < 4 * nw; k++) begin
      b = pay(v.seed, k);
      send_byte(b);
      sum = sum + b;
    end
`ifdef PROG_CHECKSUM_EN
    send_byte(8'(8'h00 - sum + v.chk_delta));
`endif
    repeat (6) @(posedge clk);
    #1;
    check({tag, " writes"}, 32'(wr_addr.size()), 32'(v.exp_writes));
    check({tag, " first_addr"}, (wr_addr.size() > 0) ? 32'(wr_addr[0]) : 32'hDEADBEEF, 32'(v.exp_first_addr));
    check({tag, " last_addr"}, (wr_addr.size() > 0) ? 32'(wr_addr[$]) : 32'hDEADBEEF, 32'(v.exp_last_addr));
    check({tag, " first_data"}, (wr_data.size() > 0) ? wr_data[0] : 32'hDEADBEEF, v.exp_first_data);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      w = {pay(v.seed, 4*i+3), pay(v.seed, 4*i+2), pay(v.seed, 4*i+1), pay(v.seed, 4*i)};
      if (wr_addr[i] !== 12'(v.addr[11:0] + 12'(i)) || wr_data[i] !== w) bad++;
    end
    check({tag, " stream_mismatches"}, 32'(bad), 32'd0);
    check({tag, " frame_ok_pulses"}, 32'(ok_cnt), 32'(v.exp_ok));
    check({tag, " frame_err_pulses"}, 32'(err_cnt), 32'(v.exp_err));
    check({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    //                addr      len    seed   dlt  wr   first    last     first_data     ok        err
    vecs[0] = '{16'h0010, 8'd1, 8'h00, 8'd0, 1,   12'h010, 12'h010, 32'h44332211, 1,        0};
    vecs[1] = '{16'h0010, 8'd1, 8'h00, 8'd1, 1,   12'h010, 12'h010, 32'h44332211, 1-CHK_ON, CHK_ON};
    vecs[2] = '{16'h0FFF, 8'd2, 8'h01, 8'd0, 2,   12'hFFF, 12'h000, 32'h45342312, 1,        0};
    vecs[3] = '{16'hF123, 8'd3, 8'h02, 8'd0, 3,   12'h123, 12'h125, 32'h46352413, 1,        0};
    vecs[4] = '{16'h0200, 8'd0, 8'h00, 8'd0, 256, 12'h200, 12'h2FF, 32'h44332211, 1,        0};
    vecs[5] = '{16'h0001, 8'd1, 8'h94, 8'd0, 1,   12'h001, 12'h001, 32'hD8C7B6A5, 1,        0};

    repeat (3) @(posedge clk);
    #1;
    check("rst m_en", 32'(m_en), 32'd0);
    check("rst m_we", 32'(m_we), 32'd0);
    check("rst m_addr", 32'(m_addr), 32'd0);
    check("rst m_data", m_data, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst s_ready", 32'(s_ready), 32'd1);
    check("rst frame_ok", 32'(frame_ok), 32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_byte(8'h00); check("garbage0 busy", 32'(busy), 32'd0);
    send_byte(8'hFF); check("garbage1 busy", 32'(busy), 32'd0);
    send_byte(8'h12); check("garbage2 busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall three bytes into the payload and let the timeout fire.
    clear_log();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    n = 0;
    while (!frame_err && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout cycles", 32'(n), 32'd100);
    check("timeout busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("timeout writes", 32'(wr_addr.size()), 32'd0);
    check("timeout err_pulses", 32'(err_cnt), 32'd1);
    check("timeout ok_pulses", 32'(ok_cnt), 32'd0);
    run_vec(vecs[0], "after_timeout");

    // Reset lands in the strobe cycle of the first word.
    clear_log();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("pre_reset strobe", 32'(m_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst m_en", 32'(m_en), 32'd0);
    check("midrst m_we", 32'(m_we), 32'd0);
    check("midrst m_addr", 32'(m_addr), 32'd0);
    check("midrst m_data", m_data, 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst s_ready", 32'(s_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst writes", 32'(wr_addr.size()), 32'd0);
    check("midrst pulses", 32'(ok_cnt + err_cnt), 32'd0);
    run_vec(vecs[0], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
